// File: rtl/adc_sample_scheduler.sv
// Two-requester arbiter/sequencer in front of the single MCP3002 SPI leader.
// Optional frame timeout and err path are built when ADC_SCHED_TIMEOUT_EN is defined.
module adc_sample_scheduler #(
  parameter int TIMEOUT = 32
) (
  input  logic       CLKsample,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic [1:0] req_ch,
  input  logic [1:0] ack,
  input  logic       frame_done,
  input  logic [7:0] sample_word,
  output logic       conv_en,
  output logic       chan_sel,
  output logic [1:0] grant,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, GRANT, CONV, DELIVER} state_t;

  // A leader frame is 16 cycles, so anything shorter would always abort.
  if (TIMEOUT < 17) begin : g_timeout_range
    $error("adc_sample_scheduler: TIMEOUT must be at least 17");
  end

  state_t     state_r, state_s;
  logic [1:0] grant_r, grant_s;
  logic       chan_sel_r, chan_sel_s;
  logic       conv_en_r, conv_en_s;
  logic [7:0] data_out_r, data_out_s;
  logic       data_valid_r, data_valid_s;
  logic       err_r, err_s;
  logic       prio_r, prio_s;

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TCNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] tcnt_r, tcnt_s;
`endif

  // Next-state and next-output decode for the arbitration sequence.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    chan_sel_s   = chan_sel_r;
    conv_en_s    = conv_en_r;
    data_out_s   = data_out_r;
    data_valid_s = data_valid_r;
    err_s        = err_r;
    prio_s       = prio_r;
`ifdef ADC_SCHED_TIMEOUT_EN
    tcnt_s       = tcnt_r;
`endif
    case (state_r)
      IDLE: begin
        case (req)
          2'b01:   begin grant_s = 2'b01; state_s = GRANT; end
          2'b10:   begin grant_s = 2'b10; state_s = GRANT; end
          2'b11:   begin grant_s = prio_r ? 2'b10 : 2'b01; state_s = GRANT; end
          default: begin grant_s = 2'b00; state_s = IDLE; end
        endcase
      end
      GRANT: begin
        chan_sel_s = grant_r[1] ? req_ch[1] : req_ch[0];
        conv_en_s  = 1'b1;
`ifdef ADC_SCHED_TIMEOUT_EN
        tcnt_s     = '0;
`endif
        state_s    = CONV;
      end
      CONV: begin
        // A frame completing on the expiry cycle still wins over the timeout.
        if (frame_done) begin
          data_out_s   = sample_word;
          conv_en_s    = 1'b0;
          data_valid_s = 1'b1;
          err_s        = 1'b0;
          state_s      = DELIVER;
        end
`ifdef ADC_SCHED_TIMEOUT_EN
        else if (tcnt_r == TCNT_LAST) begin
          data_out_s   = 8'h00;
          conv_en_s    = 1'b0;
          data_valid_s = 1'b1;
          err_s        = 1'b1;
          state_s      = DELIVER;
        end else begin
          tcnt_s = tcnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
`else
        else begin
          state_s = CONV;
        end
`endif
      end
      DELIVER: begin
        if ((ack & grant_r) != 2'b00) begin
          data_valid_s = 1'b0;
          err_s        = 1'b0;
          grant_s      = 2'b00;
          prio_s       = grant_r[0];
          state_s      = IDLE;
        end else begin
          state_s = DELIVER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLKsample or negedge RESET) begin
    if (!RESET) begin
      state_r      <= IDLE;
      grant_r      <= 2'b00;
      chan_sel_r   <= 1'b0;
      conv_en_r    <= 1'b0;
      data_out_r   <= 8'h00;
      data_valid_r <= 1'b0;
      err_r        <= 1'b0;
      prio_r       <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
      tcnt_r       <= '0;
`endif
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      chan_sel_r   <= chan_sel_s;
      conv_en_r    <= conv_en_s;
      data_out_r   <= data_out_s;
      data_valid_r <= data_valid_s;
      err_r        <= err_s;
      prio_r       <= prio_s;
`ifdef ADC_SCHED_TIMEOUT_EN
      tcnt_r       <= tcnt_s;
`endif
    end
  end

  assign conv_en    = conv_en_r;
  assign chan_sel   = chan_sel_r;
  assign grant      = grant_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign err        = err_r;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench for adc_sample_scheduler: stimulus queues expected deliveries,
// a monitor pops and compares them on each data_valid rise.
module tb_adc_sample_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] req_ch = 2'b00;
  logic [1:0] ack = 2'b00;
  logic       frame_done = 1'b0;
  logic [7:0] sample_word = 8'h00;
  logic       conv_en, chan_sel, data_valid, err;
  logic [1:0] grant;
  logic [7:0] data_out;

  typedef struct packed {
    logic [1:0] g;
    logic       ch;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_dv = 1'b0;

  adc_sample_scheduler #(.TIMEOUT(32)) dut (
    .CLKsample  (clk),
    .RESET      (rst_n),
    .req        (req),
    .req_ch     (req_ch),
    .ack        (ack),
    .frame_done (frame_done),
    .sample_word(sample_word),
    .conv_en    (conv_en),
    .chan_sel   (chan_sel),
    .grant      (grant),
    .data_out   (data_out),
    .data_valid (data_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every new delivery must match the oldest queued expectation.
  always @(negedge clk) begin
    if (data_valid && !prev_dv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery actual=%0h expected=none", data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_grant", {30'd0, grant}, {30'd0, e.g});
        check("mon_chan", {31'd0, chan_sel}, {31'd0, e.ch});
        check("mon_data", {24'd0, data_out}, {24'd0, e.d});
        check("mon_err", {31'd0, err}, {31'd0, e.e});
      end
    end
    prev_dv <= data_valid;
  end

  task automatic wait_grant(input logic [1:0] eg);
    for (int i = 0; i < 20; i++) begin
      if (grant != 2'b00) break;
      tick(1);
    end
    check("grant", {30'd0, grant}, {30'd0, eg});
  endtask

  task automatic wait_dv();
    for (int i = 0; i < 100; i++) begin
      if (data_valid) break;
      tick(1);
    end
    check("data_valid_seen", {31'd0, data_valid}, 32'd1);
  endtask

  task automatic pulse_frame(input logic [7:0] s);
    frame_done = 1'b1;
    sample_word = s;
    tick(1);
    frame_done = 1'b0;
    sample_word = 8'h00;
  endtask

  task automatic do_ack(input logic [1:0] a);
    ack = a;
    tick(1);
    ack = 2'b00;
    check("dv_after_ack", {31'd0, data_valid}, 32'd0);
    check("grant_after_ack", {30'd0, grant}, 32'd0);
  endtask

  task automatic serve(input logic [1:0] r, input logic [1:0] ch, input logic [1:0] after,
                       input logic [1:0] eg, input logic ech, input logic [7:0] s);
    req = r;
    req_ch = ch;
    wait_grant(eg);
    req = after;
    tick(1);
    check("conv_en_on", {31'd0, conv_en}, 32'd1);
    exp_q.push_back('{g: eg, ch: ech, d: s, e: 1'b0});
    pulse_frame(s);
    wait_dv();
    do_ack(eg);
  endtask

  initial begin
    tick(2);
    check("rst_conv_en", {31'd0, conv_en}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_dv", {31'd0, data_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_chan", {31'd0, chan_sel}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single requester with explicit latency and hold checks.
    req = 2'b01;
    req_ch = 2'b01;
    tick(1);
    check("t1_grant_cyc1", {30'd0, grant}, 32'd1);
    check("t1_conv_en_cyc1", {31'd0, conv_en}, 32'd0);
    req = 2'b00;
    tick(1);
    check("t1_conv_en_cyc2", {31'd0, conv_en}, 32'd1);
    check("t1_chan_cyc2", {31'd0, chan_sel}, 32'd1);
    exp_q.push_back('{g: 2'b01, ch: 1'b1, d: 8'hA5, e: 1'b0});
    pulse_frame(8'hA5);
    tick(3);
    check("t1_dv_hold", {31'd0, data_valid}, 32'd1);
    check("t1_data_hold", {24'd0, data_out}, 32'hA5);
    check("t1_conv_en_off", {31'd0, conv_en}, 32'd0);
    do_ack(2'b01);

    // Stray frame_done in IDLE.
    pulse_frame(8'hFF);
    tick(1);
    check("stray_idle_grant", {30'd0, grant}, 32'd0);
    check("stray_idle_dv", {31'd0, data_valid}, 32'd0);
    check("stray_idle_data", {24'd0, data_out}, 32'hA5);

    // Simultaneous requests: prio was set to 1 by the last delivery, so
    // requester 1 wins first here; then a fresh burst alternates again.
    serve(2'b11, 2'b10, 2'b11, 2'b10, 1'b1, 8'h11);
    serve(2'b11, 2'b10, 2'b11, 2'b01, 1'b0, 8'h22);
    serve(2'b11, 2'b10, 2'b11, 2'b10, 1'b1, 8'h33);
    serve(2'b11, 2'b10, 2'b00, 2'b01, 1'b0, 8'h44);

    // Withdrawn request, wrong-requester ack and stray frame in DELIVER.
    req = 2'b10;
    req_ch = 2'b10;
    wait_grant(2'b10);
    tick(1);
    req = 2'b00;
    exp_q.push_back('{g: 2'b10, ch: 1'b1, d: 8'h3C, e: 1'b0});
    tick(2);
    pulse_frame(8'h3C);
    wait_dv();
    ack = 2'b01;
    tick(1);
    ack = 2'b00;
    check("wrong_ack_dv", {31'd0, data_valid}, 32'd1);
    check("wrong_ack_grant", {30'd0, grant}, 32'd2);
    pulse_frame(8'h77);
    tick(1);
    check("stray_dlv_data", {24'd0, data_out}, 32'h3C);
    check("stray_dlv_dv", {31'd0, data_valid}, 32'd1);
    do_ack(2'b10);

`ifdef ADC_SCHED_TIMEOUT_EN
    req = 2'b01;
    req_ch = 2'b00;
    wait_grant(2'b01);
    req = 2'b00;
    tick(1);
    exp_q.push_back('{g: 2'b01, ch: 1'b0, d: 8'h00, e: 1'b1});
    tick(31);
    check("to_dv_before", {31'd0, data_valid}, 32'd0);
    tick(1);
    check("to_dv_at", {31'd0, data_valid}, 32'd1);
    check("to_conv_en_off", {31'd0, conv_en}, 32'd0);
    do_ack(2'b01);

    req = 2'b01;
    wait_grant(2'b01);
    req = 2'b00;
    tick(1);
    exp_q.push_back('{g: 2'b01, ch: 1'b0, d: 8'h5A, e: 1'b0});
    tick(31);
    pulse_frame(8'h5A);
    check("to_race_err", {31'd0, err}, 32'd0);
    do_ack(2'b01);
`else
    req = 2'b01;
    req_ch = 2'b00;
    wait_grant(2'b01);
    req = 2'b00;
    tick(1);
    exp_q.push_back('{g: 2'b01, ch: 1'b0, d: 8'h5A, e: 1'b0});
    tick(40);
    check("nto_dv_wait", {31'd0, data_valid}, 32'd0);
    check("nto_conv_en", {31'd0, conv_en}, 32'd1);
    pulse_frame(8'h5A);
    check("nto_err", {31'd0, err}, 32'd0);
    do_ack(2'b01);
`endif

    // Reset in the middle of CONV, then both request: reset prio picks 0.
    req = 2'b01;
    req_ch = 2'b01;
    wait_grant(2'b01);
    tick(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_conv_en", {31'd0, conv_en}, 32'd0);
    check("mid_rst_grant", {30'd0, grant}, 32'd0);
    check("mid_rst_chan", {31'd0, chan_sel}, 32'd0);
    check("mid_rst_data", {24'd0, data_out}, 32'd0);
    check("mid_rst_dv", {31'd0, data_valid}, 32'd0);
    req = 2'b00;
    tick(2);
    rst_n = 1'b1;
    serve(2'b11, 2'b00, 2'b00, 2'b01, 1'b0, 8'h69);

    tick(5);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
